// File: rtl/exec_unit_pkg.sv
// Shared encodings for the execute stage: main-control classes, R-type
// funct codes and the 4-bit ALU operation codes.
package exec_unit_pkg;

    localparam logic [1:0] ALU_OP_LDST   = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_OP_ADDI   = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_SRL = 6'b000010;

    typedef enum logic [3:0] {
        ALU_AND     = 4'b0000,
        ALU_OR      = 4'b0001,
        ALU_ADD     = 4'b0010,
        ALU_SLL     = 4'b0011,
        ALU_SRL     = 4'b0100,
        ALU_SUB     = 4'b0110,
        ALU_SLT     = 4'b0111,
        ALU_NOR     = 4'b1100,
        ALU_INVALID = 4'b1111
    } alu_ctl_e;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/exec_unit_add32.sv
// Plain 32-bit wrapping adder; carry-out is intentionally dropped.
module add32 (
    input  logic [31:0] i_x,
    input  logic [31:0] i_y,
    output logic [31:0] o_sum
);

    assign o_sum = i_x + i_y;

endmodule

// File: rtl/exec_unit_alu_decode.sv
// ALU control decode: main-control class plus funct field to ALU operation.
module alu_decode
    import exec_unit_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [5:0] i_funct,
    output logic [3:0] o_alu_ctl
);

    // Non-R-type classes select a fixed operation; R-type looks at funct.
    always_comb begin
        o_alu_ctl = ALU_ADD;
        case (i_alu_op)
            ALU_OP_BRANCH: o_alu_ctl = ALU_SUB;
            ALU_OP_RTYPE: begin
                case (i_funct)
                    FUNCT_ADD: o_alu_ctl = ALU_ADD;
                    FUNCT_SUB: o_alu_ctl = ALU_SUB;
                    FUNCT_AND: o_alu_ctl = ALU_AND;
                    FUNCT_OR:  o_alu_ctl = ALU_OR;
                    FUNCT_NOR: o_alu_ctl = ALU_NOR;
                    FUNCT_SLT: o_alu_ctl = ALU_SLT;
                    FUNCT_SLL: o_alu_ctl = ALU_SLL;
                    FUNCT_SRL: o_alu_ctl = ALU_SRL;
                    default:   o_alu_ctl = ALU_INVALID;
                endcase
            end
            default: o_alu_ctl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: ALU control decode, 32-bit ALU with zero/overflow flags,
// PC+4 and branch-target adders, and a sticky overflow status bit.
module exec_unit
    import exec_unit_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [1:0]  i_alu_op,
    input  logic [5:0]  i_funct,
    input  logic [4:0]  i_shamt,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_offset,
    output logic [3:0]  o_alu_ctl,
    output logic [31:0] o_result,
    output logic        o_zero,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_branch_target,
    output logic        o_ovf,
    output logic        o_ovf_sticky
);

    logic [3:0]  w_alu_ctl;
    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic        w_slt;
    logic [31:0] w_result;
    logic        w_ovf;
    logic        r_ovf_sticky;

    alu_decode u_alu_decode (
        .i_alu_op  (i_alu_op),
        .i_funct   (i_funct),
        .o_alu_ctl (w_alu_ctl)
    );

    add32 u_add_pc4 (
        .i_x   (i_pc),
        .i_y   (PC_STEP),
        .o_sum (o_pc_plus4)
    );

    add32 u_add_branch (
        .i_x   (o_pc_plus4),
        .i_y   (i_offset),
        .o_sum (o_branch_target)
    );

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;

    // With differing signs the negative operand is the smaller one; with equal
    // signs the subtraction cannot overflow, so its sign bit is trustworthy.
    assign w_slt = (i_a[31] != i_b[31]) ? i_a[31] : w_diff[31];

    // ALU result selection; unlisted codes (including INVALID) yield zero.
    always_comb begin
        w_result = '0;
        case (w_alu_ctl)
            ALU_AND: w_result = i_a & i_b;
            ALU_OR:  w_result = i_a | i_b;
            ALU_NOR: w_result = ~(i_a | i_b);
            ALU_ADD: w_result = w_sum;
            ALU_SUB: w_result = w_diff;
            ALU_SLT: w_result = {31'd0, w_slt};
            ALU_SLL: w_result = i_b << i_shamt;
            ALU_SRL: w_result = i_b >> i_shamt;
            default: w_result = '0;
        endcase
    end

    // Signed overflow is only meaningful for ADD and SUB.
    always_comb begin
        w_ovf = 1'b0;
        case (w_alu_ctl)
            ALU_ADD: w_ovf = (i_a[31] == i_b[31]) && (w_sum[31]  != i_a[31]);
            ALU_SUB: w_ovf = (i_a[31] != i_b[31]) && (w_diff[31] != i_a[31]);
            default: w_ovf = 1'b0;
        endcase
    end

    // Sticky overflow: reset wins over a same-cycle overflow.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ovf_sticky <= 1'b0;
        end else begin
            r_ovf_sticky <= r_ovf_sticky | w_ovf;
        end
    end

    assign o_alu_ctl    = w_alu_ctl;
    assign o_result     = w_result;
    assign o_zero       = (w_result == 32'd0);
    assign o_ovf        = w_ovf;
    assign o_ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: directed test-plan steps followed by random steps,
// all checked against an arithmetic reference model.
module tb_exec_unit;

    logic        clk;
    logic        reset;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] a, b, pc, offset;
    logic [3:0]  alu_ctl;
    logic [31:0] result;
    logic        zero;
    logic [31:0] pc_plus4, branch_target;
    logic        ovf, ovf_sticky;

    int errors = 0;
    int checks = 0;
    logic exp_sticky;

    exec_unit dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_alu_op        (alu_op),
        .i_funct         (funct),
        .i_shamt         (shamt),
        .i_a             (a),
        .i_b             (b),
        .i_pc            (pc),
        .i_offset        (offset),
        .o_alu_ctl       (alu_ctl),
        .o_result        (result),
        .o_zero          (zero),
        .o_pc_plus4      (pc_plus4),
        .o_branch_target (branch_target),
        .o_ovf           (ovf),
        .o_ovf_sticky    (ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: operation table and signed arithmetic on wide integers.
    function automatic logic [3:0] m_ctl(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b01) return 4'b0110;
        if (op != 2'b10) return 4'b0010;
        case (f)
            6'h20:   return 4'b0010;
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h27:   return 4'b1100;
            6'h2a:   return 4'b0111;
            6'h00:   return 4'b0011;
            6'h02:   return 4'b0100;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic longint m_sx(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic [31:0] m_res(input logic [3:0] c, input logic [31:0] x,
                                          input logic [31:0] y, input logic [4:0] sh);
        longint r;
        case (c)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b1100: return ~(x | y);
            4'b0010: begin r = m_sx(x) + m_sx(y); return r[31:0]; end
            4'b0110: begin r = m_sx(x) - m_sx(y); return r[31:0]; end
            4'b0111: return (m_sx(x) < m_sx(y)) ? 32'd1 : 32'd0;
            4'b0011: return y << sh;
            4'b0100: return y >> sh;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_ovf(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        longint r;
        longint max_i = 64'sh7FFFFFFF;
        longint min_i = -64'sh80000000;
        if (c == 4'b0010)      r = m_sx(x) + m_sx(y);
        else if (c == 4'b0110) r = m_sx(x) - m_sx(y);
        else                   return 1'b0;
        return (r > max_i) || (r < min_i);
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one operand set, check combinational outputs, clock once and
    // check the sticky flag against the modelled accumulation.
    task automatic step(input string tag, input logic [1:0] op, input logic [5:0] f,
                        input logic [4:0] sh, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] p, input logic [31:0] off, input logic rst);
        logic [3:0]  ec;
        logic [31:0] er;
        logic        eo;
        alu_op = op; funct = f; shamt = sh; a = x; b = y; pc = p; offset = off; reset = rst;
        #1;
        ec = m_ctl(op, f);
        er = m_res(ec, x, y, sh);
        eo = m_ovf(ec, x, y);
        chk32({tag, ".ctl"}, {28'd0, alu_ctl}, {28'd0, ec});
        chk32({tag, ".res"}, result, er);
        chk32({tag, ".zero"}, {31'd0, zero}, {31'd0, (er == 32'd0)});
        chk32({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
        chk32({tag, ".pc4"}, pc_plus4, p + 32'd4);
        chk32({tag, ".bt"}, branch_target, p + 32'd4 + off);
        exp_sticky = rst ? 1'b0 : (exp_sticky | eo);
        @(posedge clk);
        #1;
        chk32({tag, ".sticky"}, {31'd0, ovf_sticky}, {31'd0, exp_sticky});
    endtask

    logic [5:0]  flist [9];
    logic [31:0] edge_v [6];

    initial begin
        logic [5:0]  rf;
        logic [31:0] ra, rb;
        flist  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h00, 6'h02, 6'h3f};
        edge_v = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h55};

        reset = 1'b1; alu_op = 2'b00; funct = 6'h0; shamt = 5'd0;
        a = 32'd0; b = 32'd0; pc = 32'd0; offset = 32'd0;
        exp_sticky = 1'b0;
        @(posedge clk);
        #1;
        chk32("reset.sticky", {31'd0, ovf_sticky}, 32'd0);

        step("radd", 2'b10, 6'h20, 5'd0, 32'd10, 32'd20, 32'h0, 32'h0, 1'b0);
        chk32("radd.const", result, 32'd30);
        step("beq", 2'b01, 6'h3f, 5'd0, 32'h55, 32'h55, 32'h100, 32'h8, 1'b0);
        chk32("beq.zero", {31'd0, zero}, 32'd1);
        step("bne", 2'b01, 6'h00, 5'd0, 32'h55, 32'h56, 32'h100, 32'h8, 1'b0);
        chk32("bne.res", result, 32'hFFFFFFFF);
        step("slt1", 2'b10, 6'h2a, 5'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1'b0);
        chk32("slt1.const", result, 32'd1);
        step("slt2", 2'b10, 6'h2a, 5'd0, 32'h7FFFFFFF, 32'h80000000, 32'h0, 32'h0, 1'b0);
        chk32("slt2.const", result, 32'd0);
        step("sll", 2'b10, 6'h00, 5'd4, 32'hDEADBEEF, 32'h80000001, 32'h0, 32'h0, 1'b0);
        chk32("sll.const", result, 32'h00000010);
        step("srl", 2'b10, 6'h02, 5'd4, 32'hDEADBEEF, 32'h80000001, 32'h0, 32'h0, 1'b0);
        chk32("srl.const", result, 32'h08000000);
        step("addovf", 2'b11, 6'h00, 5'd0, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 1'b0);
        chk32("addovf.sticky", {31'd0, ovf_sticky}, 32'd1);
        step("clean", 2'b00, 6'h00, 5'd0, 32'h1, 32'h1, 32'h0, 32'h0, 1'b0);
        chk32("clean.sticky", {31'd0, ovf_sticky}, 32'd1);
        step("rstovf", 2'b11, 6'h00, 5'd0, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 1'b1);
        chk32("rstovf.sticky", {31'd0, ovf_sticky}, 32'd0);
        step("addr", 2'b00, 6'h00, 5'd0, 32'h4, 32'h8, 32'h00400000, 32'hFFFFFFF8, 1'b0);
        chk32("addr.bt", branch_target, 32'h003FFFFC);
        step("wrap", 2'b00, 6'h00, 5'd0, 32'h4, 32'h8, 32'hFFFFFFFC, 32'h0, 1'b0);
        chk32("wrap.pc4", pc_plus4, 32'h0);
        step("inv", 2'b10, 6'h3f, 5'd3, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, 1'b0);
        chk32("inv.ctl", {28'd0, alu_ctl}, 32'hF);

        for (int i = 0; i < 300; i++) begin
            rf = ($urandom_range(0, 3) == 0) ? 6'($urandom) : flist[$urandom_range(0, 8)];
            ra = ($urandom_range(0, 2) == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 2) == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
            step("rand", 2'($urandom), rf, 5'($urandom), ra, rb, $urandom, $urandom,
                 ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
# exec_unit

Combinational execute stage of the single-cycle MIPS datapath: it decodes `alu_op` and `funct` into a 4-bit ALU operation and computes the ALU result and zero flag. It also computes the PC+4 and branch-target addresses. It sits between the register file / sign-extend logic and the data memory and branch mux. The only state is a sticky overflow status register.

## Interface
- Parameters: none (datapath fixed at 32 bits).
- `clk` input 1: clock; only the sticky overflow register uses it.
- `reset` input 1: synchronous, active-high.
- `alu_op` input 2: main-control class; 00 = load/store, 01 = branch, 10 = R-type, 11 = immediate add.
- `funct` input 6: instruction[5:0].
- `shamt` input 5: instruction[10:6].
- `a` input 32: register read data 1 (rs).
- `b` input 32: ALU-source mux output (rt or sign-extended immediate).
- `pc` input 32: current program counter.
- `offset` input 32: sign-extended immediate already shifted left by 2.
- `alu_ctl` output 4: decoded ALU operation.
- `result` output 32: ALU result.
- `zero` output 1: high when `result == 0`.
- `pc_plus4` output 32: `pc + 4`.
- `branch_target` output 32: `pc_plus4 + offset`.
- `ovf` output 1: combinational signed overflow of ADD/SUB.
- `ovf_sticky` output 1: registered OR of `ovf`.

## Operation
- ALU control decode:
  - `alu_op` 00 or 11 → ADD 0010.
  - `alu_op` 01 → SUB 0110.
  - `alu_op` 10 decodes `funct`:
    - 100000 → ADD 0010.
    - 100010 → SUB 0110.
    - 100100 → AND 0000.
    - 100101 → OR 0001.
    - 100111 → NOR 1100.
    - 101010 → SLT 0111.
    - 000000 → SLL 0011.
    - 000010 → SRL 0100.
    - any other `funct` → INVALID 1111.
  - Addu/subu are not distinguished.
- ALU functions:
  - AND: `a & b`.
  - OR: `a | b`.
  - NOR: `~(a | b)`.
  - ADD: `a + b`, modulo 2^32.
  - SUB: `a - b`, modulo 2^32.
  - SLT: 1 if `$signed(a) < $signed(b)`, else 0. Compute it from the sign comparison, so it is correct even when the subtraction overflows.
  - SLL: `b << shamt`. SRL: `b >> shamt` (logical). Neither shift uses `a`.
  - INVALID or any unlisted `alu_ctl` code: result 0.
- `zero` is derived from `result` for every operation, including INVALID (which gives `zero` = 1).
- `ovf`:
  - ADD: high when `a` and `b` have the same sign and `result` has the opposite sign.
  - SUB: high when `a` and `b` differ in sign and `result` sign differs from `a`.
  - All other operations: 0.
  - `ovf` does not suppress or alter `result`; no trap is raised.
- Address adders: 32-bit unsigned, wrap modulo 2^32, carry-out discarded. `branch_target` is computed every cycle, independent of the branch decision.

## Timing
- All outputs except `ovf_sticky` are purely combinational: zero-cycle latency, no handshake. They settle within the single-cycle datapath period.
- `ovf_sticky`:
  - On a `clk` rising edge with `reset` = 1: becomes 0.
  - Otherwise: becomes `ovf_sticky | ovf`.
  - Reset has priority over a simultaneous overflow.
- Reset value: `ovf_sticky` = 0. The combinational outputs are unaffected by reset and follow their inputs during reset.
- Wrap-around: `pc` = 0xFFFFFFFC gives `pc_plus4` = 0x00000000; a negative `offset` wraps the same way.

## Structure
- Shared package holds:
  - `alu_op` encodings.
  - `funct` constants.
  - The 4-bit ALU operation codes, including INVALID.
- Sub-modules:
  - `alu_decode`: combinational control decode.
  - `add32`: plain 32-bit adder with no carry-out, instantiated twice (PC+4 and branch target).
- The ALU body and the overflow register live in the top module.

## Test plan
- R-type ADD, `alu_op`=10, `funct`=100000, `a`=10, `b`=20 → `alu_ctl`=0010, `result`=30, `zero`=0, `ovf`=0.
- Branch compare, `alu_op`=01, `a`=b=0x55 → SUB, `result`=0, `zero`=1. Same with `a`=0x55, `b`=0x56 → `result`=0xFFFFFFFF, `zero`=0.
- SLT, `alu_op`=10, `funct`=101010:
  - `a`=0xFFFFFFFF, `b`=1 → 1.
  - `a`=0x7FFFFFFF, `b`=0x80000000 → 0 (overflow-safe).
- Shifts, `b`=0x80000001, `shamt`=4:
  - SLL → 0x00000010.
  - SRL → 0x08000000.
- Overflow: ADD `a`=0x7FFFFFFF, `b`=1 → `result`=0x80000000, `ovf`=1. `ovf_sticky` = 1 after the next edge and stays 1 with clean inputs. A synchronous `reset` pulse clears it to 0, even while `ovf`=1.
- Addresses: `pc`=0x00400000, `offset`=0xFFFFFFF8 → `pc_plus4`=0x00400004, `branch_target`=0x003FFFFC. `pc`=0xFFFFFFFC → `pc_plus4`=0. Unknown `funct` 111111 with `alu_op`=10 → `alu_ctl`=1111, `result`=0, `zero`=1.
